// File: rtl/sd_dev_data_tx_ctrl.sv
// rtl/sd_dev_data_tx_ctrl.sv - SD device 4-bit data block transmit sequencer
// Optional NAC lead-in slots enabled by macro SD_DEV_TX_NAC_EN.
module sd_dev_data_tx_ctrl #(
  parameter int          BLK_W    = 12,
  parameter logic [15:0] CRC_INIT = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_locked,
  input  logic             i_sd_slot_stb,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [BLK_W-1:0] i_block_size,
`ifdef SD_DEV_TX_NAC_EN
  input  logic [7:0]       i_nac_slots,
`endif
  input  logic [7:0]       i_data,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  output logic             o_sd_data_dir,
  output logic [7:0]       o_sd_data_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef SD_DEV_TX_NAC_EN
    S_NAC,
`endif
    S_DATA,
    S_CRC,
    S_END
  } state_t;

  state_t           state_q, state_d;
  logic [BLK_W:0]   cnt_q;
  logic [BLK_W:0]   n_q;
  logic [BLK_W:0]   n_plus8;
  logic [3:0][15:0] crc_q;
  logic [3:0][15:0] crc_fold;
  logic [3:0]       low_q;
  logic [3:0]       crc_hi;
  logic [3:0]       crc_lo;
  logic [7:0]       byte_in;
  logic             accept;
  logic             fetch;
`ifdef SD_DEV_TX_NAC_EN
  logic [7:0]       nac_q;
`endif

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    crc_bit = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign accept  = (state_q == S_IDLE) && i_start && i_locked &&
                   (i_block_size != '0) && !i_abort;
  assign fetch   = i_sd_slot_stb && !i_abort && (state_q == S_DATA) && (cnt_q != n_q);
  assign byte_in = i_data_valid ? i_data : 8'h00;
  assign n_plus8 = n_q + (BLK_W+1)'(8);
  assign crc_hi  = {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]};
  assign crc_lo  = {crc_q[3][14], crc_q[2][14], crc_q[1][14], crc_q[0][14]};

  assign o_data_ready = fetch;

  // Each lane takes bit L of the high nibble first, then bit L of the low nibble.
  always_comb begin
    crc_fold = crc_q;
    for (int l = 0; l < 4; l++) begin
      crc_fold[l] = crc_bit(crc_bit(crc_q[l], byte_in[l+4]), byte_in[l]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
`ifdef SD_DEV_TX_NAC_EN
            state_d = (i_nac_slots != 8'd0) ? S_NAC : S_DATA;
`else
            state_d = S_DATA;
`endif
          end
        end
`ifdef SD_DEV_TX_NAC_EN
        S_NAC:  if (i_sd_slot_stb && nac_q == 8'd1) state_d = S_DATA;
`endif
        S_DATA: if (i_sd_slot_stb && cnt_q == n_q) state_d = S_CRC;
        S_CRC:  if (i_sd_slot_stb && cnt_q == n_plus8) state_d = S_END;
        S_END:  if (i_sd_slot_stb) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sd_data_out <= 8'hFF;
      o_sd_data_dir <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_underrun    <= 1'b0;
      cnt_q         <= '0;
      n_q           <= '0;
      low_q         <= 4'h0;
      for (int l = 0; l < 4; l++) crc_q[l] <= CRC_INIT;
`ifdef SD_DEV_TX_NAC_EN
      nac_q         <= 8'd0;
`endif
    end else begin
      o_done <= 1'b0;
      if (i_abort) begin
        o_sd_data_dir <= 1'b0;
        o_sd_data_out <= 8'hFF;
        o_busy        <= 1'b0;
      end else if (accept) begin
        n_q        <= {1'b0, i_block_size};
        cnt_q      <= '0;
        o_busy     <= 1'b1;
        o_underrun <= 1'b0;
        low_q      <= 4'h0;
        for (int l = 0; l < 4; l++) crc_q[l] <= CRC_INIT;
`ifdef SD_DEV_TX_NAC_EN
        nac_q      <= i_nac_slots;
`endif
      end else if (i_sd_slot_stb) begin
        case (state_q)
`ifdef SD_DEV_TX_NAC_EN
          S_NAC: begin
            o_sd_data_dir <= 1'b1;
            o_sd_data_out <= 8'hFF;
            nac_q         <= nac_q - 8'd1;
          end
`endif
          S_DATA: begin
            o_sd_data_dir <= 1'b1;
            cnt_q         <= cnt_q + 1'b1;
            if (cnt_q != n_q) begin
              o_sd_data_out <= {low_q, byte_in[7:4]};
              low_q         <= byte_in[3:0];
              crc_q         <= crc_fold;
              if (!i_data_valid) o_underrun <= 1'b1;
            end else begin
              // Last payload nibble pairs with C0; shift so C1 sits at bit 15.
              o_sd_data_out <= {low_q, crc_hi};
              for (int l = 0; l < 4; l++) crc_q[l] <= {crc_q[l][14:0], 1'b0};
            end
          end
          S_CRC: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == n_plus8) begin
              o_sd_data_out <= {crc_hi, 4'hF};
            end else begin
              o_sd_data_out <= {crc_hi, crc_lo};
              for (int l = 0; l < 4; l++) crc_q[l] <= {crc_q[l][13:0], 2'b00};
            end
          end
          S_END: begin
            o_sd_data_dir <= 1'b0;
            o_sd_data_out <= 8'hFF;
            o_busy        <= 1'b0;
            o_done        <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_dev_data_tx_ctrl.sv
// tb/tb_sd_dev_data_tx_ctrl.sv - self-checking bench for sd_dev_data_tx_ctrl
module tb_sd_dev_data_tx_ctrl;
  localparam int BLK_W = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_locked = 1'b1;
  logic             i_sd_slot_stb = 1'b0;
  logic             i_start = 1'b0;
  logic             i_abort = 1'b0;
  logic [BLK_W-1:0] i_block_size = '0;
`ifdef SD_DEV_TX_NAC_EN
  logic [7:0]       i_nac_slots = 8'd0;
`endif
  logic [7:0]       i_data = 8'h00;
  logic             i_data_valid = 1'b0;
  logic             o_data_ready;
  logic             o_sd_data_dir;
  logic [7:0]       o_sd_data_out;
  logic             o_busy;
  logic             o_done;
  logic             o_underrun;

  int checks = 0;
  int failures = 0;
  int ready_cnt;
  logic       model_under;
  logic [7:0] tx_bytes  [0:511];
  logic [7:0] exp_slots [0:527];

  sd_dev_data_tx_ctrl #(.BLK_W(BLK_W), .CRC_INIT(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_locked     (i_locked),
    .i_sd_slot_stb(i_sd_slot_stb),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_block_size (i_block_size),
`ifdef SD_DEV_TX_NAC_EN
    .i_nac_slots  (i_nac_slots),
`endif
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .o_sd_data_dir(o_sd_data_dir),
    .o_sd_data_out(o_sd_data_out),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_underrun   (o_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ccitt_bit(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // Nibble stream on the wire: start, payload (high first), 16 CRC nibbles, end.
  task automatic build_expected(input int n, input int under_idx);
    logic [3:0]  nib [$];
    logic [15:0] crc [4];
    logic [7:0]  b;
    for (int l = 0; l < 4; l++) crc[l] = 16'h0000;
    nib.push_back(4'h0);
    for (int k = 0; k < n; k++) begin
      b = (k == under_idx) ? 8'h00 : tx_bytes[k];
      nib.push_back(b[7:4]);
      nib.push_back(b[3:0]);
      for (int l = 0; l < 4; l++) crc[l] = ccitt_bit(ccitt_bit(crc[l], b[4+l]), b[l]);
    end
    for (int j = 0; j < 16; j++)
      nib.push_back({crc[3][15-j], crc[2][15-j], crc[1][15-j], crc[0][15-j]});
    nib.push_back(4'hF);
    for (int s = 0; s < n + 9; s++) exp_slots[s] = {nib[2*s], nib[2*s+1]};
  endtask

  task automatic idle_gap(input int idle_max);
    repeat ($urandom_range(idle_max, 1)) @(negedge clk);
  endtask

  task automatic run_xfer(input int n, input int under_idx, input int idle_max, input int nac,
                          input int busy_start_slot, input int lock_drop_slot, input int abort_slot);
    build_expected(n, under_idx);
    @(negedge clk);
    i_start = 1'b1;
    i_block_size = BLK_W'(n);
`ifdef SD_DEV_TX_NAC_EN
    i_nac_slots = 8'(nac);
`endif
    @(negedge clk);
    i_start = 1'b0;
    i_block_size = '0;
    model_under = 1'b0;
    check("busy_after_start", o_busy, 1);
    check("underrun_cleared", o_underrun, 0);
    check("dir_before_slot0", o_sd_data_dir, 0);
    ready_cnt = 0;
    for (int q = 0; q < nac; q++) begin
      i_sd_slot_stb = 1'b1;
      i_abort = (abort_slot == -2 && q == 1);
      @(negedge clk);
      i_sd_slot_stb = 1'b0;
      if (abort_slot == -2 && q == 1) begin
        i_abort = 1'b0;
        check("nac_abort_dir", o_sd_data_dir, 0);
        check("nac_abort_busy", o_busy, 0);
        return;
      end
      check($sformatf("nac%0d_out", q), o_sd_data_out, 8'hFF);
      check($sformatf("nac%0d_dir", q), o_sd_data_dir, 1);
      idle_gap(idle_max);
    end
    for (int s = 0; s < n + 9; s++) begin
      i_sd_slot_stb = 1'b1;
      i_locked = (s != lock_drop_slot);
      i_abort = (s == abort_slot);
      if (s == busy_start_slot) begin
        i_start = 1'b1;
        i_block_size = BLK_W'(1);
      end
      if (s < n) begin
        i_data = tx_bytes[s];
        i_data_valid = (s != under_idx);
      end else begin
        i_data = 8'($urandom);
        i_data_valid = 1'b1;
      end
      #1;
      if (o_data_ready) ready_cnt++;
      if (s != abort_slot) check($sformatf("ready_slot%0d", s), o_data_ready, (s < n));
      @(negedge clk);
      i_sd_slot_stb = 1'b0;
      i_start = 1'b0;
      i_locked = 1'b1;
      i_data_valid = 1'b0;
      if (s == under_idx) model_under = 1'b1;
      if (s == abort_slot) begin
        i_abort = 1'b0;
        check("abort_dir", o_sd_data_dir, 0);
        check("abort_out", o_sd_data_out, 8'hFF);
        check("abort_busy", o_busy, 0);
        check("abort_underrun_held", o_underrun, model_under);
        repeat (3) begin
          i_sd_slot_stb = 1'b1;
          @(negedge clk);
          i_sd_slot_stb = 1'b0;
          check("abort_no_done", o_done, 0);
          check("abort_stays_idle", o_sd_data_dir, 0);
          @(negedge clk);
        end
        return;
      end
      check($sformatf("slot%0d_out", s), o_sd_data_out, exp_slots[s]);
      check($sformatf("slot%0d_dir", s), o_sd_data_dir, 1);
      check($sformatf("slot%0d_busy", s), o_busy, 1);
      check($sformatf("slot%0d_done", s), o_done, 0);
      if (s == under_idx) check("underrun_set", o_underrun, 1);
      idle_gap(idle_max);
    end
    i_sd_slot_stb = 1'b1;
    @(negedge clk);
    i_sd_slot_stb = 1'b0;
    check("end_dir", o_sd_data_dir, 0);
    check("end_out", o_sd_data_out, 8'hFF);
    check("end_busy", o_busy, 0);
    check("end_done", o_done, 1);
    check("end_underrun", o_underrun, model_under);
    check("ready_count", ready_cnt, n);
    @(negedge clk);
    check("done_one_clk", o_done, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out", o_sd_data_out, 8'hFF);
    check("rst_dir", o_sd_data_dir, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_underrun", o_underrun, 0);
    check("rst_ready", o_data_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte A5: slot 0 must be 0A and the frame 10 slots long.
    tx_bytes[0] = 8'hA5;
    build_expected(1, -1);
    check("t1_model_slot0", exp_slots[0], 8'h0A);
    run_xfer(1, -1, 1, 0, -1, -1, -1);

    for (int k = 0; k < 512; k++) tx_bytes[k] = 8'(k);
    run_xfer(512, -1, 4, 0, -1, -1, -1);

    for (int k = 0; k < 4; k++) tx_bytes[k] = 8'($urandom);
    run_xfer(4, 2, 2, 0, -1, -1, -1);

    for (int k = 0; k < 8; k++) tx_bytes[k] = 8'($urandom);
    run_xfer(8, 1, 2, 0, -1, -1, 3);
    check("abort_then_underrun_still", o_underrun, 1);
    run_xfer(8, -1, 2, 0, -1, -1, -1);

    // Start gating while idle.
    i_locked = 1'b0;
    i_start = 1'b1;
    i_block_size = BLK_W'(5);
    @(negedge clk);
    i_start = 1'b0;
    i_locked = 1'b1;
    check("gate_unlocked_busy", o_busy, 0);
    i_start = 1'b1;
    i_block_size = '0;
    @(negedge clk);
    i_start = 1'b0;
    check("gate_size0_busy", o_busy, 0);
    i_sd_slot_stb = 1'b1;
    @(negedge clk);
    i_sd_slot_stb = 1'b0;
    check("gate_no_dir", o_sd_data_dir, 0);

    // Restart attempt while busy and locked dropping mid-transfer are ignored.
    for (int k = 0; k < 20; k++) tx_bytes[k] = 8'($urandom);
    run_xfer(20, -1, 2, 0, 5, 2, -1);

    repeat (3) begin
      automatic int n = $urandom_range(40, 1);
      for (int k = 0; k < n; k++) tx_bytes[k] = 8'($urandom);
      run_xfer(n, int'($urandom_range(n - 1, 0)), 3, 0, -1, -1, -1);
    end

`ifdef SD_DEV_TX_NAC_EN
    for (int k = 0; k < 4; k++) tx_bytes[k] = 8'($urandom);
    run_xfer(4, -1, 2, 3, -1, -1, -1);
    run_xfer(4, -1, 2, 3, -1, -1, -2);
`endif

    // Asynchronous reset in the middle of DATA, between clock edges.
    for (int k = 0; k < 8; k++) tx_bytes[k] = 8'($urandom);
    @(negedge clk);
    i_start = 1'b1;
    i_block_size = BLK_W'(8);
    @(negedge clk);
    i_start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      i_sd_slot_stb = 1'b1;
      i_data = tx_bytes[s];
      i_data_valid = (s != 0);
      @(negedge clk);
      i_sd_slot_stb = 1'b0;
      @(negedge clk);
    end
    check("pre_rst_dir", o_sd_data_dir, 1);
    check("pre_rst_underrun", o_underrun, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", o_sd_data_out, 8'hFF);
    check("async_rst_dir", o_sd_data_dir, 0);
    check("async_rst_busy", o_busy, 0);
    check("async_rst_underrun", o_underrun, 0);
    check("async_rst_done", o_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer(3, -1, 2, 0, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
